// File: rtl/ram_dual_be.sv
// ram_dual_be
// Single-clock simple dual-port synchronous RAM. It has per-lane write byte
// enables, a selectable same-address read-during-write behaviour, an optional
// output pipeline register, a read-valid strobe and an optional zero-fill of
// the whole array after reset.
//
// Ports:
//   clk        clock; all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   wen        write request
//   waddr      write address
//   wdata      write data
//   wbe        write lane enables; bit i covers wdata[i*SYM_WIDTH +: SYM_WIDTH]
//   ren        read request
//   raddr      read address
//   rdata      read data; holds its last value when rvalid is low
//   rvalid     one pulse per accepted read, aligned with its rdata
//   init_busy  zero-fill in progress; wen/ren are ignored while high
module ram_dual_be #(
  parameter int D_WIDTH    = 16,
  parameter int A_WIDTH    = 5,
  parameter int SYM_WIDTH  = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wen,
  input  logic [A_WIDTH-1:0]             waddr,
  input  logic [D_WIDTH-1:0]             wdata,
  input  logic [D_WIDTH/SYM_WIDTH-1:0]   wbe,
  input  logic                           ren,
  input  logic [A_WIDTH-1:0]             raddr,
  output logic [D_WIDTH-1:0]             rdata,
  output logic                           rvalid,
  output logic                           init_busy
);

  localparam int N_SYM = D_WIDTH / SYM_WIDTH;
  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

  // Lanes must tile the data word exactly, otherwise wbe cannot describe it.
  if ((D_WIDTH % SYM_WIDTH) != 0) begin : g_bad_width
    $error("ram_dual_be: D_WIDTH must be an integer multiple of SYM_WIDTH");
  end

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [A_WIDTH-1:0]   cnt;
  logic [A_WIDTH-1:0]   cnt_next;

  logic [D_WIDTH-1:0]   mem [DEPTH];

  logic                 wr_acc;
  logic                 rd_acc;
  logic [D_WIDTH-1:0]   wr_merged;
  logic [D_WIDTH-1:0]   rd_word;

  logic [D_WIDTH-1:0]   s1_data;
  logic                 s1_valid;

  assign init_busy = (state == S_CLEAR);
  assign wr_acc    = wen & ~init_busy;
  assign rd_acc    = ren & ~init_busy;

  // State register and fill counter. Reset restarts the fill from address 0
  // when zero-fill is enabled, otherwise the RAM is usable straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. The terminal compare is made on the last address so the
  // counter can stay A_WIDTH bits wide and never wraps into a second fill.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_CLEAR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      end
      S_RUN: begin
        state_next = S_RUN;
      end
      default: begin
        state_next = S_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // The word that ram[waddr] becomes after this write: enabled lanes come
  // from wdata, the rest keep their stored value.
  always_comb begin
    wr_merged = mem[waddr];
    for (int i = 0; i < N_SYM; i++) begin
      if (wbe[i]) begin
        wr_merged[i*SYM_WIDTH +: SYM_WIDTH] = wdata[i*SYM_WIDTH +: SYM_WIDTH];
      end
    end
  end

  // Read source. In new-data mode a same-address write forwards the merged
  // word, which already holds stored data in the disabled lanes.
  always_comb begin
    rd_word = mem[raddr];
    if ((RDW_MODE != 0) && wr_acc && (waddr == raddr)) begin
      rd_word = wr_merged;
    end
  end

  // Memory array. It is never reset; the fill sequence zeroes it one word per
  // cycle and user writes are locked out until the fill has finished.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      mem[waddr] <= wr_merged;
    end
  end

  // First read stage. Data only moves on an accepted read so that rdata holds
  // the last result between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [D_WIDTH-1:0] s2_data;
    logic               s2_valid;

    // Optional output register adding one cycle of read latency; it follows
    // the same hold-on-idle rule as the first stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rdata  = s2_data;
    assign rvalid = s2_valid;
  end else begin : g_no_out_reg
    assign rdata  = s1_data;
    assign rvalid = s1_valid;
  end

endmodule

// File: tb/tb_ram_dual_be.sv
// tb_ram_dual_be
// Self-checking bench for ram_dual_be. Three instances share one stimulus:
//   dutA  RDW_MODE=0, OUT_REG=0, INIT_CLEAR=1  (old data, latency 1)
//   dutB  RDW_MODE=1, OUT_REG=1, INIT_CLEAR=1  (new data, latency 2)
//   dutC  RDW_MODE=0, OUT_REG=0, INIT_CLEAR=0  (no zero-fill)
// All use D_WIDTH=16, A_WIDTH=4, SYM_WIDTH=8.
module tb_ram_dual_be;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic        ren;
  logic [3:0]  raddr;

  logic [15:0] rdataA, rdataB, rdataC;
  logic        rvalidA, rvalidB, rvalidC;
  logic        busyA, busyB, busyC;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wbe;
    logic        ren;
    logic [3:0]  raddr;
    logic        expValidA;
    logic [15:0] expDataA;
    logic        expValidB;
    logic [15:0] expDataB;
  } vec_t;

  vec_t vecs[13];

  ram_dual_be #(.D_WIDTH(16), .A_WIDTH(4), .SYM_WIDTH(8),
                .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)) dutA (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .ren(ren), .raddr(raddr), .rdata(rdataA), .rvalid(rvalidA),
    .init_busy(busyA)
  );

  ram_dual_be #(.D_WIDTH(16), .A_WIDTH(4), .SYM_WIDTH(8),
                .RDW_MODE(1), .OUT_REG(1), .INIT_CLEAR(1)) dutB (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .ren(ren), .raddr(raddr), .rdata(rdataB), .rvalid(rvalidB),
    .init_busy(busyB)
  );

  ram_dual_be #(.D_WIDTH(16), .A_WIDTH(4), .SYM_WIDTH(8),
                .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(0)) dutC (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .ren(ren), .raddr(raddr), .rdata(rdataC), .rvalid(rvalidC),
    .init_busy(busyC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then settle for sampling.
  task automatic applyStimulus(input logic w, input logic [3:0] wa,
                               input logic [15:0] wd, input logic [1:0] be,
                               input logic r, input logic [3:0] ra);
    wen   = w;
    waddr = wa;
    wdata = wd;
    wbe   = be;
    ren   = r;
    raddr = ra;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, check the reset state, release on a negedge.
  task automatic doReset();
    wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset rdataA", rdataA, 16'h0000);
    checkOutput("reset rvalidA", 16'(rvalidA), 16'h0);
    checkOutput("reset rdataB", rdataB, 16'h0000);
    checkOutput("reset rvalidB", 16'(rvalidB), 16'h0);
    checkOutput("reset busyA", 16'(busyA), 16'h1);
    checkOutput("reset busyB", 16'(busyB), 16'h1);
    checkOutput("reset busyC", 16'(busyC), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run the zero-fill while hammering addr 5 with writes and reads; they must
  // all be dropped. init_busy must cover exactly 16 posedges.
  task automatic runClearPhase(input string tag);
    int cycA = 0;
    int cycB = 0;
    wen = 1'b1; waddr = 4'd5; wdata = 16'hFFFF; wbe = 2'b11;
    ren = 1'b1; raddr = 4'd5;
    for (int c = 0; c < 100 && (busyA || busyB); c++) begin
      if (busyA) cycA++;
      if (busyB) cycB++;
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s clear rvalidA c%0d", tag, c), 16'(rvalidA), 16'h0);
      checkOutput($sformatf("%s clear rvalidB c%0d", tag, c), 16'(rvalidB), 16'h0);
      checkOutput($sformatf("%s clear busyC c%0d", tag, c), 16'(busyC), 16'h0);
    end
    checkOutput($sformatf("%s busy cycles A", tag), 16'(cycA), 16'd16);
    checkOutput($sformatf("%s busy cycles B", tag), 16'(cycB), 16'd16);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
      checkOutput($sformatf("%s post rvalidA %0d", tag, c), 16'(rvalidA), 16'h0);
      checkOutput($sformatf("%s post rvalidB %0d", tag, c), 16'(rvalidB), 16'h0);
    end
  endtask

  initial begin
    // Vector table: outputs are sampled after the posedge that consumes the
    // row, so A shows this row's read and B shows the previous row's read.
    //            wen   waddr  wdata     wbe    ren   raddr  vA    dataA     vB    dataB
    vecs[0]  = '{1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'hA5C3, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0, 1'b0, 16'hA5C3, 1'b1, 16'hA5C3};
    vecs[3]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'hA534, 1'b0, 16'hA5C3};
    vecs[4]  = '{1'b1, 4'd3, 16'hBEEF, 2'b10, 1'b1, 4'd3, 1'b1, 16'hA534, 1'b1, 16'hA534};
    vecs[5]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'hBE34, 1'b1, 16'hBE34};
    vecs[6]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 16'hBE34, 1'b1, 16'hBE34};
    vecs[7]  = '{1'b1, 4'd7, 16'h1111, 2'b11, 1'b1, 4'd7, 1'b1, 16'h0000, 1'b0, 16'hBE34};
    vecs[8]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b1, 16'h1111};
    vecs[9]  = '{1'b1, 4'd8, 16'h2222, 2'b11, 1'b1, 4'd7, 1'b1, 16'h1111, 1'b0, 16'h1111};
    vecs[10] = '{1'b1, 4'd8, 16'hFFFF, 2'b00, 1'b1, 4'd8, 1'b1, 16'h2222, 1'b1, 16'h1111};
    vecs[11] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd8, 1'b1, 16'h2222, 1'b1, 16'h2222};
    vecs[12] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 16'h2222, 1'b1, 16'h2222};

    $display("[TB] reset and zero-fill with blocked traffic");
    doReset();
    runClearPhase("init");

    $display("[TB] back-to-back readback of the cleared array");
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, (i < 16), 4'(i));
      checkOutput($sformatf("fill rvalidA %0d", i), 16'(rvalidA), 16'(i < 16));
      checkOutput($sformatf("fill rdataA %0d", i), rdataA, 16'h0000);
      checkOutput($sformatf("fill rvalidB %0d", i), 16'(rvalidB), 16'(i >= 1));
      checkOutput($sformatf("fill rdataB %0d", i), rdataB, 16'h0000);
    end

    $display("[TB] byte-enable and read-during-write table");
    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].wen, vecs[v].waddr, vecs[v].wdata, vecs[v].wbe,
                    vecs[v].ren, vecs[v].raddr);
      checkOutput($sformatf("vec%0d rvalidA", v), 16'(rvalidA), 16'(vecs[v].expValidA));
      checkOutput($sformatf("vec%0d rdataA", v), rdataA, vecs[v].expDataA);
      checkOutput($sformatf("vec%0d rvalidB", v), 16'(rvalidB), 16'(vecs[v].expValidB));
      checkOutput($sformatf("vec%0d rdataB", v), rdataB, vecs[v].expDataB);
    end

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
    checkOutput("inflight rvalidA", 16'(rvalidA), 16'h1);
    checkOutput("inflight rdataA", rdataA, 16'hBE34);
    checkOutput("inflight rvalidB", 16'(rvalidB), 16'h0);
    raddr = 4'd4;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst rdataA", rdataA, 16'h0000);
    checkOutput("async rst rvalidA", 16'(rvalidA), 16'h0);
    checkOutput("async rst rdataB", rdataB, 16'h0000);
    checkOutput("async rst rvalidB", 16'(rvalidB), 16'h0);
    checkOutput("async rst busyB", 16'(busyB), 16'h1);
    ren = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    runClearPhase("rerun");

    $display("[TB] no zero-fill instance");
    checkOutput("C busy after reset", 16'(busyC), 16'h0);
    applyStimulus(1'b1, 4'd15, 16'h00FF, 2'b11, 1'b0, 4'd0);
    checkOutput("C write rvalid", 16'(rvalidC), 16'h0);
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd15);
    checkOutput("C read rvalid", 16'(rvalidC), 16'h1);
    checkOutput("C read rdata", rdataC, 16'h00FF);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
      checkOutput($sformatf("C idle rvalid %0d", c), 16'(rvalidC), 16'h0);
      checkOutput($sformatf("C idle rdata %0d", c), rdataC, 16'h00FF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
